// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU units: operation encodings and the small
// decode helpers that turn an opcode into the adder's operand controls.
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDC = 2'b10,
        OP_SUBB = 2'b11
    } alu_op_e;

    // Subtraction is done as a + ~b + cin, so the B operand is inverted.
    function automatic logic op_is_sub(input alu_op_e op);
        return (op == OP_SUB) || (op == OP_SUBB);
    endfunction

    // Carry into the adder LSB. For SUBB, c_in = 1 means "no borrow".
    function automatic logic op_carry_in(input alu_op_e op, input logic c_in);
        logic ci;
        case (op)
            OP_ADD:  ci = 1'b0;
            OP_SUB:  ci = 1'b1;
            OP_ADDC: ci = c_in;
            OP_SUBB: ci = c_in;
            default: ci = 1'b0;
        endcase
        return ci;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// ---------------------------------------------------------------------------
// alu_res_fifo
// Result buffer: synchronous FIFO of DEPTH entries of WIDTH bits.
// DEPTH must be a power of two; pointers wrap naturally modulo DEPTH.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (pointers and count)
//   push    : write wr_data (ignored when full and not popping)
//   wr_data : entry to write
//   pop     : remove head entry (ignored when empty)
//   rd_data : head entry, forced to zero while empty
//   count   : number of stored entries, 0..DEPTH
//   empty   : count == 0
// ---------------------------------------------------------------------------
module alu_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer can still take a write in the same cycle it pops.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_addsub_pipe.sv
// ---------------------------------------------------------------------------
// alu_addsub_pipe
// Two-stage add/subtract unit with valid/ready handshake on both sides.
// Stage 1 registers the operand set; its result is written into a small
// result buffer on the following edge, so an accepted operation appears at
// the output two edges after acceptance when the buffer was empty.
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   a_valid_data   : upstream offers an operand set
//   a_ready_data   : block accepts an operand set this cycle
//   add_1, add_2   : operands (DATA_SIZE bits)
//   c_in           : carry-in (ADDC) / not-borrow (SUBB)
//   op             : 00 ADD, 01 SUB, 10 ADDC, 11 SUBB
//   id_add         : tag returned with the result
//   a_valid_res    : result buffer not empty
//   res_ready      : downstream takes the head result
//   result_add     : {id, ovf, c_out, sum}
//   busy           : an operation is in stage 1 or buffered
// ---------------------------------------------------------------------------
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int ID_SIZE   = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          a_valid_data,
    output logic                          a_ready_data,
    input  logic [DATA_SIZE-1:0]          add_1,
    input  logic [DATA_SIZE-1:0]          add_2,
    input  logic                          c_in,
    input  logic [1:0]                    op,
    input  logic [ID_SIZE-1:0]            id_add,
    output logic                          a_valid_res,
    input  logic                          res_ready,
    output logic [ID_SIZE+DATA_SIZE+1:0]  result_add,
    output logic                          busy
);

    localparam int RES_W = ID_SIZE + DATA_SIZE + 2;
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

    // Returns {ovf, c_out, sum} for a + b' + cin.
    function automatic logic [DATA_SIZE+1:0] addsub(
        input logic signed [DATA_SIZE-1:0] a,
        input logic signed [DATA_SIZE-1:0] b,
        input logic                        cin_raw,
        input alu_op_e                     opc
    );
        logic [DATA_SIZE-1:0] bx;
        logic                 ci;
        logic [DATA_SIZE:0]   full;
        logic                 ovf;
        bx   = op_is_sub(opc) ? ~b : b;
        ci   = op_carry_in(opc, cin_raw);
        full = {1'b0, a} + {1'b0, bx} + {{DATA_SIZE{1'b0}}, ci};
        ovf  = (a[DATA_SIZE-1] == bx[DATA_SIZE-1]) &&
               (full[DATA_SIZE-1] != a[DATA_SIZE-1]);
        return {ovf, full};
    endfunction

    logic                        accept;
    logic                        vld_p1;
    logic signed [DATA_SIZE-1:0] a_p1;
    logic signed [DATA_SIZE-1:0] b_p1;
    logic                        cin_p1;
    alu_op_e                     op_p1;
    logic [ID_SIZE-1:0]          id_p1;
    logic [RES_W-1:0]            res_p1;
    logic [CNT_W-1:0]            count;
    logic                        fifo_empty;
    logic [CNT_W:0]              occupancy;

    // Occupancy counts the stage-1 slot too. Accepting only while it is at
    // most OUT_DEPTH-2 guarantees every in-flight result has a buffer slot,
    // so ready never has to look at res_ready.
    assign occupancy    = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
    assign a_ready_data = (occupancy <= (CNT_W+1)'(OUT_DEPTH - 2));
    assign accept       = a_valid_data && a_ready_data;

    // ---- stage 0 -> stage 1: operand capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1   <= add_1;
            b_p1   <= add_2;
            cin_p1 <= c_in;
            op_p1  <= alu_op_e'(op);
            id_p1  <= id_add;
        end
    end

    assign res_p1 = {id_p1, addsub(a_p1, b_p1, cin_p1, op_p1)};

    // ---- stage 1 -> result buffer ----
    alu_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (OUT_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (vld_p1),
        .wr_data (res_p1),
        .pop     (res_ready),
        .rd_data (result_add),
        .count   (count),
        .empty   (fifo_empty)
    );

    assign a_valid_res = !fifo_empty;
    assign busy        = vld_p1 || !fifo_empty;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
module tb_alu_addsub_pipe;

    localparam int DS = 16;
    localparam int IS = 8;
    localparam int OD = 4;
    localparam int RW = IS + DS + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid_data = 1'b0;
    logic          a_ready_data;
    logic [DS-1:0] add_1 = '0;
    logic [DS-1:0] add_2 = '0;
    logic          c_in = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [IS-1:0] id_add = '0;
    logic          a_valid_res;
    logic          res_ready = 1'b0;
    logic [RW-1:0] result_add;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int accepts = 0;

    // Reference: ordered list of expected results and the cycle each one
    // becomes visible (two cycles after its accept cycle).
    logic [RW-1:0] exp_q[$];
    int            rdy_q[$];

    alu_addsub_pipe #(.DATA_SIZE(DS), .ID_SIZE(IS), .OUT_DEPTH(OD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid_data (a_valid_data),
        .a_ready_data (a_ready_data),
        .add_1        (add_1),
        .add_2        (add_2),
        .c_in         (c_in),
        .op           (op),
        .id_add       (id_add),
        .a_valid_res  (a_valid_res),
        .res_ready    (res_ready),
        .result_add   (result_add),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Plain integer arithmetic on the mathematical values of the operands.
    function automatic logic [RW-1:0] ref_result(input logic [DS-1:0] a, input logic [DS-1:0] b,
                                                 input logic ci, input logic [1:0] o,
                                                 input logic [IS-1:0] id);
        longint ua, ub, sa, sb, cil, u, s;
        logic   c, ovf;
        logic [DS-1:0] sum;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        cil = ci ? 64'sd1 : 64'sd0;
        case (o)
            2'b00:   begin u = ua + ub;             s = sa + sb;             end
            2'b01:   begin u = ua - ub;             s = sa - sb;             end
            2'b10:   begin u = ua + ub + cil;       s = sa + sb + cil;       end
            default: begin u = ua - ub - (1 - cil); s = sa - sb - (1 - cil); end
        endcase
        if (o[0]) c = (u >= 0);
        else      c = (u >= 65536);
        ovf = (s > 32767) || (s < -32768);
        sum = u[DS-1:0];
        return {id, ovf, c, sum};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [DS-1:0] a, input logic [DS-1:0] b, input logic ci,
                         input logic [1:0] o, input logic [IS-1:0] id);
        add_1 = a; add_2 = b; c_in = ci; op = o; id_add = id;
        a_valid_data = 1'b1;
    endtask

    task automatic drive_rand(input logic [IS-1:0] id);
        drive(DS'($urandom), DS'($urandom), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), id);
    endtask

    // One clock cycle: compare outputs against the model, record the
    // handshakes that will happen at the coming edge, then advance.
    task automatic tick();
        bit acc, pp, exp_vld;
        exp_vld = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
        chk("a_valid_res", a_valid_res, exp_vld);
        chk("busy", busy, exp_q.size() > 0);
        chk("a_ready_data", a_ready_data, exp_q.size() <= OD - 2);
        if (a_valid_res && exp_q.size() > 0) chk("result_head", result_add, exp_q[0]);
        acc = a_valid_data && a_ready_data;
        pp  = a_valid_res && res_ready;
        if (pp && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(rdy_q.pop_front());
            pops++;
        end
        if (acc) begin
            exp_q.push_back(ref_result(add_1, add_2, c_in, op, id_add));
            rdy_q.push_back(cyc + 2);
            accepts++;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        a_valid_data = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 40 && (busy || a_valid_res); k++) tick();
        chk("drain_done_busy", busy, 1'b0);
        chk("drain_model_empty", exp_q.size(), 0);
        res_ready = 1'b0;
    endtask

    initial begin
        int p0, a0, vcnt;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_a_valid_res", a_valid_res, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result_add", result_add, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_a_ready_data", a_ready_data, 1'b1);

        // Signed overflow on ADD, 2-cycle latency
        drive(16'h7FFF, 16'h0001, 1'b0, 2'b00, 8'h05);
        tick();
        a_valid_data = 1'b0;
        tick();
        chk("add_ovf_result", result_add, {8'h05, 1'b1, 1'b0, 16'h8000});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // SUB with borrow, SUBB with borrow-in
        drive(16'h0003, 16'h0005, 1'b0, 2'b01, 8'h11);
        tick();
        drive(16'h0003, 16'h0002, 1'b0, 2'b11, 8'h12);
        tick();
        a_valid_data = 1'b0;
        tick();
        chk("sub_borrow", result_add, {8'h11, 1'b0, 1'b0, 16'hFFFE});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("subb_borrow_in", result_add, {8'h12, 1'b0, 1'b1, 16'h0000});
        res_ready = 1'b1;
        tick();

        // ADDC carry propagation
        drive(16'hFFFF, 16'h0000, 1'b1, 2'b10, 8'h21);
        tick();
        a_valid_data = 1'b0;
        tick();
        chk("addc_carry", result_add, {8'h21, 1'b0, 1'b1, 16'h0000});
        drain();

        // 20 back-to-back accepts with res_ready held high
        p0 = pops; a0 = accepts; vcnt = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_rand(IS'(8'h40 + i));
            if (a_valid_res) vcnt++;
            tick();
        end
        a_valid_data = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (a_valid_res) vcnt++;
            tick();
        end
        chk("b2b_accepts", accepts - a0, 20);
        chk("b2b_pops", pops - p0, 20);
        chk("b2b_one_per_cycle", vcnt, 20);
        drain();

        // Back-pressure: res_ready low, upstream always valid
        a0 = accepts; p0 = pops;
        res_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_rand(IS'(8'h80 + i));
            tick();
        end
        chk("bp_ready_low", a_ready_data, 1'b0);
        chk("bp_valid_res", a_valid_res, 1'b1);
        chk("bp_held", accepts - a0, OD - 1);
        drain();
        chk("bp_drained", pops - p0, OD - 1);

        // Randomised mixed traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) drive_rand(IS'(i));
            else a_valid_data = 1'b0;
            res_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();

        // Reset while two results are buffered
        res_ready = 1'b0;
        drive(16'h1234, 16'h1111, 1'b0, 2'b00, 8'hA1);
        tick();
        drive(16'h2000, 16'h0001, 1'b0, 2'b01, 8'hA2);
        tick();
        a_valid_data = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", a_valid_res, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_a_valid_res", a_valid_res, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_result_add", result_add, '0);
        exp_q.delete();
        rdy_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(16'h8000, 16'h8000, 1'b0, 2'b00, 8'h5A);
        tick();
        a_valid_data = 1'b0;
        tick();
        chk("post_rst_result", result_add, {8'h5A, 1'b1, 1'b1, 16'h0000});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
